// File: rtl/game_flow_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : game_flow_ctrl (with package states)
//  Purpose  : Gomoku top-level sequencer: avatar selection, turn arbitration,
//             win-checker handshake, winner/draw declaration and rematch.
//             Optional turn timer enabled by defining TURN_TIMER_EN.
//  Revision : 1.0 - initial release
// ============================================================================

package states;
  typedef logic [1:0] state_t;
  localparam state_t S_SELECT_P1 = 2'd0;
  localparam state_t S_SELECT_P2 = 2'd1;
  localparam state_t S_PLAY      = 2'd2;
  localparam state_t S_WIN       = 2'd3;
endpackage

module game_flow_ctrl
  import states::*;
#(
  parameter int BOARD_CELLS = 225,
  parameter int AVATAR_W    = 3,
  parameter int TURN_TICKS  = 30,
  localparam int CNT_W      = $clog2(BOARD_CELLS + 1),
  localparam int TMR_W      = $clog2(TURN_TICKS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_1hz,
  input  logic                confirm,
  input  logic                restart,
  input  logic [AVATAR_W-1:0] avatar_sel,
  input  logic                move_req,
  input  logic                move_legal,
  input  logic                win_valid,
  input  logic                win_found,
  output state_t              state,
  output logic [AVATAR_W-1:0] p1_avatar,
  output logic [AVATAR_W-1:0] p2_avatar,
  output logic                cur_player,
  output logic                place_en,
  output logic                check_start,
  output logic                board_clear,
  output logic [1:0]          winner,
  output logic [CNT_W-1:0]    move_count,
  output logic [TMR_W-1:0]    turn_timer
);

  localparam logic [CNT_W-1:0] c_cells = CNT_W'(BOARD_CELLS);

  state_t              r_state;
  logic [AVATAR_W-1:0] r_p1_avatar;
  logic [AVATAR_W-1:0] r_p2_avatar;
  logic                r_cur_player;
  logic                r_place_en;
  logic                r_check_start;
  logic                r_board_clear;
  logic [1:0]          r_winner;
  logic [CNT_W-1:0]    r_move_count;
  logic                r_busy;

  logic w_idle_play;
  logic w_move_ok;
  logic w_result;
  logic w_timeout;

  assign w_idle_play = (r_state == S_PLAY) && !r_busy;
  assign w_move_ok   = w_idle_play && move_req && move_legal;
  // Busy means a stone is placed and its win-check result is outstanding.
  assign w_result    = (r_state == S_PLAY) && r_busy && win_valid;

  always_ff @(posedge clk) begin
    r_place_en    <= 1'b0;
    r_check_start <= 1'b0;
    r_board_clear <= 1'b0;
    if (rst) begin
      r_state      <= S_SELECT_P1;
      r_p1_avatar  <= '0;
      r_p2_avatar  <= '0;
      r_cur_player <= 1'b0;
      r_winner     <= 2'd0;
      r_move_count <= '0;
      r_busy       <= 1'b0;
    end else if (restart) begin
      r_state       <= S_SELECT_P1;
      r_p1_avatar   <= '0;
      r_p2_avatar   <= '0;
      r_cur_player  <= 1'b0;
      r_winner      <= 2'd0;
      r_move_count  <= '0;
      r_busy        <= 1'b0;
      r_board_clear <= 1'b1;
    end else begin
      case (r_state)
        S_SELECT_P1: begin
          if (confirm) begin
            r_p1_avatar <= avatar_sel;
            r_state     <= S_SELECT_P2;
          end
        end
        S_SELECT_P2: begin
          if (confirm && (avatar_sel != r_p1_avatar)) begin
            r_p2_avatar   <= avatar_sel;
            r_state       <= S_PLAY;
            r_board_clear <= 1'b1;
            r_cur_player  <= 1'b0;
            r_move_count  <= '0;
            r_winner      <= 2'd0;
            r_busy        <= 1'b0;
          end
        end
        S_PLAY: begin
          if (w_move_ok) begin
            r_place_en    <= 1'b1;
            r_check_start <= 1'b1;
            r_busy        <= 1'b1;
            if (r_move_count < c_cells) begin
              r_move_count <= r_move_count + CNT_W'(1);
            end
          end else if (w_result) begin
            r_busy <= 1'b0;
            if (win_found) begin
              r_state  <= S_WIN;
              r_winner <= {1'b0, r_cur_player} + 2'd1;
            end else if (r_move_count == c_cells) begin
              r_state  <= S_WIN;
              r_winner <= 2'd3;
            end else begin
              r_cur_player <= ~r_cur_player;
            end
          end else if (w_timeout) begin
            r_cur_player <= ~r_cur_player;
          end
        end
        S_WIN: begin
          if (confirm) begin
            r_state       <= S_PLAY;
            r_board_clear <= 1'b1;
            r_move_count  <= '0;
            r_winner      <= 2'd0;
            r_busy        <= 1'b0;
            // Loser opens the rematch; a draw (3) or P2 win hands it to P1.
            r_cur_player  <= (r_winner == 2'd1);
          end
        end
        default: r_state <= S_SELECT_P1;
      endcase
    end
  end

`ifdef TURN_TIMER_EN
  localparam logic [TMR_W-1:0] c_tmr_full = TMR_W'(TURN_TICKS);

  logic [TMR_W-1:0] r_turn_timer;
  logic             w_play_entry;
  logic             w_turn_change;
  logic             w_tick_dec;

  assign w_play_entry  = ((r_state == S_SELECT_P2) && confirm && (avatar_sel != r_p1_avatar))
                       || ((r_state == S_WIN) && confirm);
  assign w_turn_change = w_result && !win_found && (r_move_count != c_cells);
  // A legal move in the same cycle as a tick takes precedence over the tick.
  assign w_tick_dec    = w_idle_play && tick_1hz && !w_move_ok;
  assign w_timeout     = w_tick_dec && (r_turn_timer == TMR_W'(1));

  // Reaching zero forfeits the turn; the reload happens on the following cycle.
  always_ff @(posedge clk) begin
    if (rst || restart || w_play_entry || w_turn_change || (r_turn_timer == '0)) begin
      r_turn_timer <= c_tmr_full;
    end else if (w_tick_dec) begin
      r_turn_timer <= r_turn_timer - TMR_W'(1);
    end
  end

  assign turn_timer = r_turn_timer;
`else
  logic w_unused;

  assign w_timeout  = 1'b0;
  assign turn_timer = '0;
  assign w_unused   = &{1'b0, tick_1hz};
`endif

  assign state       = r_state;
  assign p1_avatar   = r_p1_avatar;
  assign p2_avatar   = r_p2_avatar;
  assign cur_player  = r_cur_player;
  assign place_en    = r_place_en;
  assign check_start = r_check_start;
  assign board_clear = r_board_clear;
  assign winner      = r_winner;
  assign move_count  = r_move_count;

endmodule

`default_nettype wire

// File: tb/tb_game_flow_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_game_flow_ctrl
//  Purpose  : Directed vector table, timer corner sequence and randomized run
//             against a rule-level game model for game_flow_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================

module tb_game_flow_ctrl;

  localparam int BC = 4;
  localparam int AW = 3;
  localparam int TT = 3;
  localparam int CW = $clog2(BC + 1);
  localparam int TW = $clog2(TT + 1);
`ifdef TURN_TIMER_EN
  localparam int HAS_TMR = 1;
`else
  localparam int HAS_TMR = 0;
`endif
  localparam int TT_IDLE = HAS_TMR ? TT : 0;

  localparam int PH_SEL1 = 0, PH_SEL2 = 1, PH_PLAY = 2, PH_WIN = 3;

  logic          clk = 1'b0;
  logic          rst, tick_1hz, confirm, restart, move_req, move_legal, win_valid, win_found;
  logic [AW-1:0] avatar_sel;
  logic [1:0]    state;
  logic [AW-1:0] p1_avatar, p2_avatar;
  logic          cur_player, place_en, check_start, board_clear;
  logic [1:0]    winner;
  logic [CW-1:0] move_count;
  logic [TW-1:0] turn_timer;

  always #5 clk = ~clk;

  game_flow_ctrl #(.BOARD_CELLS(BC), .AVATAR_W(AW), .TURN_TICKS(TT)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .confirm(confirm), .restart(restart),
    .avatar_sel(avatar_sel), .move_req(move_req), .move_legal(move_legal),
    .win_valid(win_valid), .win_found(win_found), .state(state),
    .p1_avatar(p1_avatar), .p2_avatar(p2_avatar), .cur_player(cur_player),
    .place_en(place_en), .check_start(check_start), .board_clear(board_clear),
    .winner(winner), .move_count(move_count), .turn_timer(turn_timer)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef logic [18:0] obs_t;

  typedef struct {
    logic cf, rs, mr, ml, wv, wf;
    int   av;
    int   st, p1, p2, cur, pl, ck, clr, win, cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic obs_t pk(input int st, p1, p2, cur, pl, ck, clr, win, cnt, tmr);
    return {2'(st), 3'(p1), 3'(p2), 1'(cur), 1'(pl), 1'(ck), 1'(clr), 2'(win), 3'(cnt), 2'(tmr)};
  endfunction

  function automatic vec_t mk(input logic cf, rs, mr, ml, wv, wf, input int av,
                              input int st, p1, p2, cur, pl, ck, clr, win, cnt);
    vec_t v;
    v.cf = cf; v.rs = rs; v.mr = mr; v.ml = ml; v.wv = wv; v.wf = wf; v.av = av;
    v.st = st; v.p1 = p1; v.p2 = p2; v.cur = cur; v.pl = pl; v.ck = ck;
    v.clr = clr; v.win = win; v.cnt = cnt;
    return v;
  endfunction

  task automatic drive(input logic r, cf, rs, mr, ml, wv, wf, tk, input int av);
    rst = r; confirm = cf; restart = rs; move_req = mr; move_legal = ml;
    win_valid = wv; win_found = wf; tick_1hz = tk; avatar_sel = AW'(av);
    @(posedge clk);
    #1;
  endtask

  task automatic compare(input string name, input obs_t exp);
    obs_t act;
    act = {state, p1_avatar, p2_avatar, cur_player, place_en, check_start,
           board_clear, winner, move_count, turn_timer};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got st/p1/p2/cur/pl/ck/clr/win/cnt/tmr=%b, want %b", name, act, exp);
    end
  endtask

  // Rule-level game model: one call per clock with that cycle's inputs.
  int m_phase, m_p1, m_p2, m_cur, m_win, m_cnt, m_pl, m_ck, m_clr;
  bit m_waiting;

  task automatic new_game(input int first);
    m_phase = PH_PLAY; m_clr = 1; m_cnt = 0; m_win = 0; m_cur = first; m_waiting = 0;
  endtask

  task automatic model_step(input logic r, cf, rs, mr, ml, wv, wf, input int av);
    m_pl = 0; m_ck = 0; m_clr = 0;
    if (r || rs) begin
      m_phase = PH_SEL1; m_p1 = 0; m_p2 = 0; m_cur = 0; m_win = 0; m_cnt = 0;
      m_waiting = 0; m_clr = r ? 0 : 1;
    end else if (m_phase == PH_SEL1) begin
      if (cf) begin m_p1 = av; m_phase = PH_SEL2; end
    end else if (m_phase == PH_SEL2) begin
      if (cf && av != m_p1) begin m_p2 = av; new_game(0); end
    end else if (m_phase == PH_PLAY) begin
      if (!m_waiting) begin
        if (mr && ml) begin
          m_pl = 1; m_ck = 1; m_waiting = 1;
          m_cnt = (m_cnt + 1 > BC) ? BC : m_cnt + 1;
        end
      end else if (wv) begin
        m_waiting = 0;
        if (wf) begin m_phase = PH_WIN; m_win = m_cur + 1; end
        else if (m_cnt == BC) begin m_phase = PH_WIN; m_win = 3; end
        else m_cur = 1 - m_cur;
      end
    end else begin
      if (cf) new_game(m_win == 1 ? 1 : 0);
    end
  endtask

  initial begin
    int tmr2, tmr1;
    logic cf, rs, mr, ml, wv, wf;
    int av;

    rst = 1'b1; tick_1hz = 0; confirm = 0; restart = 0; move_req = 0;
    move_legal = 0; win_valid = 0; win_found = 0; avatar_sel = '0;

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    compare("reset", pk(PH_SEL1, 0, 0, 0, 0, 0, 0, 0, 0, TT_IDLE));

    //              cf rs mr ml wv wf av   st p1 p2 cur pl ck clr win cnt
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 2,   1, 2, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 2,   1, 2, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 5,   2, 2, 5, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   2, 2, 5, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0,   2, 2, 5, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0,   2, 2, 5, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 1, 0, 0, 0,   2, 2, 5, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,   2, 2, 5, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,   2, 2, 5, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0,   2, 2, 5, 1, 1, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0,   3, 2, 5, 1, 0, 0, 0, 2, 2));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0,   3, 2, 5, 1, 0, 0, 0, 2, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,   2, 2, 5, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0,   2, 2, 5, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,   2, 2, 5, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0,   2, 2, 5, 1, 1, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,   2, 2, 5, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0,   2, 2, 5, 0, 1, 1, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,   2, 2, 5, 1, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0,   2, 2, 5, 1, 1, 1, 0, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,   3, 2, 5, 1, 0, 0, 0, 3, 4));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,   2, 2, 5, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0,   2, 2, 5, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0,   3, 2, 5, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,   2, 2, 5, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0,   2, 2, 5, 1, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1,   1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 3,   2, 1, 3, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0,   2, 1, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 1, 0, 0, 0,   2, 1, 3, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0, 0));

    foreach (tbl[i]) begin
      drive(0, tbl[i].cf, tbl[i].rs, tbl[i].mr, tbl[i].ml, tbl[i].wv, tbl[i].wf, 0, tbl[i].av);
      compare($sformatf("row%0d", i),
              pk(tbl[i].st, tbl[i].p1, tbl[i].p2, tbl[i].cur, tbl[i].pl, tbl[i].ck,
                 tbl[i].clr, tbl[i].win, tbl[i].cnt, TT_IDLE));
    end

    // Turn timer: expiry forfeits the turn; a legal move on the expiring tick wins.
    tmr2 = HAS_TMR ? 2 : 0;
    tmr1 = HAS_TMR ? 1 : 0;
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
    compare("tmr_sel1", pk(1, 0, 0, 0, 0, 0, 0, 0, 0, TT_IDLE));
    drive(0, 1, 0, 0, 0, 0, 0, 0, 1);
    compare("tmr_entry", pk(2, 0, 1, 0, 0, 0, 1, 0, 0, TT_IDLE));
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    compare("tmr_dec2", pk(2, 0, 1, 0, 0, 0, 0, 0, 0, tmr2));
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    compare("tmr_dec1", pk(2, 0, 1, 0, 0, 0, 0, 0, 0, tmr1));
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    compare("tmr_expire", pk(2, 0, 1, HAS_TMR, 0, 0, 0, 0, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    compare("tmr_reload", pk(2, 0, 1, HAS_TMR, 0, 0, 0, 0, 0, TT_IDLE));
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    compare("tmr_pre_race", pk(2, 0, 1, HAS_TMR, 0, 0, 0, 0, 0, tmr1));
    drive(0, 0, 0, 1, 1, 0, 0, 1, 0);
    compare("tmr_race", pk(2, 0, 1, HAS_TMR, 1, 1, 0, 0, 1, tmr1));
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    compare("tmr_busy_hold", pk(2, 0, 1, HAS_TMR, 0, 0, 0, 0, 1, tmr1));
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    compare("tmr_turn_reload", pk(2, 0, 1, 1 - HAS_TMR, 0, 0, 0, 0, 1, TT_IDLE));

    // Randomized play against the rule model (no ticks, so the timer stays idle).
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0, 0, 0, 0);
    compare("rand_reset", pk(m_phase, m_p1, m_p2, m_cur, m_pl, m_ck, m_clr, m_win, m_cnt, TT_IDLE));
    for (int n = 0; n < 4000; n++) begin
      cf = ($urandom_range(0, 5) == 0);
      rs = ($urandom_range(0, 79) == 0);
      mr = ($urandom_range(0, 3) == 0);
      ml = ($urandom_range(0, 3) != 0);
      wv = ($urandom_range(0, 3) == 0);
      wf = ($urandom_range(0, 4) == 0);
      av = $urandom_range(0, 3);
      drive(0, cf, rs, mr, ml, wv, wf, 0, av);
      model_step(0, cf, rs, mr, ml, wv, wf, av);
      compare($sformatf("rand%0d", n),
              pk(m_phase, m_p1, m_p2, m_cur, m_pl, m_ck, m_clr, m_win, m_cnt, TT_IDLE));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
